horner_multiply_adder: RTL and testbench
========================================

Name: horner_multiply_adder

Overview:
- Datapath responder for the polynomial-correction control FSM.
- Each multiplyadder_in_ready pulse triggers one Horner step: acc <= x*acc + a[coefficent_select].
- When the step completes, the block returns multiplyadder_out_ready plus the updated accumulator.
- Sits between the ADC centering/scaling stage (supplies x) and the control FSM (sequences coefficient selects 10..0).

Parameters:
- DATA_W, 16, signed fixed-point width of x, coefficients and accumulator.
- FRAC_W, 12, fractional bits (Q4.12 default).
- NUM_COEF, 11, number of coefficients a0..a10.
- COEFS, all zero, packed NUM_COEF*DATA_W vector; a_k occupies bits [k*DATA_W +: DATA_W].

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- adc_input_ready  in  1  latch x_in this cycle.
- x_in  in  DATA_W  signed sample x[n].
- multiplyadder_in_ready  in  1  start-step pulse.
- coefficent_select  in  4  coefficient index for this step.
- multiplyadder_out_ready  out  1  one-cycle step-done pulse.
- multiplyadder_result  out  DATA_W  signed accumulator value.
- busy  out  1  step in progress.
- overrun_err  out  1  sticky: start pulse ignored.
- sel_err  out  1  sticky: coefficent_select > NUM_COEF-1.

Behaviour:
- Reset (reset low, async): all outputs 0, acc=0, x_reg=0, state IDLE, serial multiplier cleared.
- x capture: adc_input_ready high while state IDLE -> x_reg <= x_in. Ignored (no error) outside IDLE.
- States:
  - IDLE --in_ready--> MUL.
  - MUL: DATA_W cycles, count 0..DATA_W-1 --> DONE.
  - DONE: one cycle --> IDLE.
- Start edge E0 (IDLE, in_ready=1):
  - Latch coefficient a[sel].
  - Operand A = x_reg.
  - Operand B = 0 if sel==NUM_COEF-1 (first Horner step, accumulator cleared), else acc.
  - busy=1.
- MUL: signed shift-add on magnitudes, one bit per edge; sign applied at completion.
- Final edge E_{DATA_W+1}, entering DONE:
  - prod = A*B (2*DATA_W bits), then arithmetic shift right by FRAC_W.
  - sum = prod_shifted + coef in DATA_W+2 bits.
  - Reduce to DATA_W bits (see Optional Feature), store to acc and multiplyadder_result.
  - multiplyadder_out_ready=1 for exactly that one cycle.
- Latency: out_ready and result valid DATA_W+1 cycles after the sampling edge (17 by default).
- busy high in MUL and DONE; cleared entering IDLE.
- in_ready while busy: ignored, overrun_err<=1, acc untouched.
- sel > NUM_COEF-1: coef treated as 0, step still runs, sel_err<=1.
- Sticky error flags clear only on reset.
- multiplyadder_result holds between steps.
- Reset mid-MUL: abort immediately; no out_ready pulse; next step behaves as after power-up.

Optional Feature:
- Macro HORNER_MAC_SATURATE_EN.
- Defined: sum clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Undefined: sum truncated to low DATA_W bits (two's-complement wrap).

Decomposition:
- Package horner_pkg:
  - DATA_W and FRAC_W defaults.
  - NUM_COEF, COEF_SEL_W=4.
  - State encoding IDLE/MUL/DONE.
  - Saturation-limit constants.
- Sub-module horner_serial_mult: start/done handshake, signed DATA_W x DATA_W sequential multiplier, fixed DATA_W-cycle latency.
- Top holds FSM, coefficient mux, accumulator and error flags.

Test Plan:
- Reset: assert reset low mid-run -> all outputs 0 immediately; after release, first step with x=4096, a10=4096, sel=10 -> result 4096.
- Single steps: x=2048 (0.5), a10=4096, a9=1024. sel=10 -> out_ready 17 cycles later, result 4096. Then sel=9 -> result 3072.
- Full sequence: x=4096 (1.0), all a_k=256, sel 10..0 driven by the control FSM -> 11 out_ready pulses, final result 2816.
- Overflow: x=4096, a10=30000, a9=30000, sel 10 then 9 -> 32767 with HORNER_MAC_SATURATE_EN defined; -5536 without.
- Protocol errors: in_ready 5 cycles into MUL -> ignored, overrun_err=1, result unchanged. sel=12 -> step runs with coef 0, sel_err=1.
- Negative operands: x=-2048, a10=4096, then a9=0 -> result -2048; check arithmetic shift is correct for negative products.

Source files
------------

// File: rtl/horner_pkg.sv
// Shared constants and types for the Horner multiply-add datapath.
package horner_pkg;

  localparam int unsigned DATA_W_DEFAULT   = 16;
  localparam int unsigned FRAC_W_DEFAULT   = 12;
  localparam int unsigned NUM_COEF_DEFAULT = 11;
  localparam int unsigned COEF_SEL_W       = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Two's-complement limits of a w-bit signed value.
  function automatic longint sat_hi(int unsigned w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(int unsigned w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/horner_serial_mult.sv
// Sequential signed multiplier: magnitudes are shift-added one bit per clock and the
// sign is applied to the finished product. done pulses DATA_W cycles after start.
module horner_serial_mult
  import horner_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  output logic                       done,
  output logic signed [2*DATA_W-1:0] product
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [2*DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [2*DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                run_q;
  logic                neg_q;
  logic                done_q;

  // Magnitude as an unsigned value; the most negative input maps to 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] mag(logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? DATA_W'(-v) : DATA_W'(v);
  endfunction

  // Load operands on start, then consume one multiplier bit per clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        mcand_q  <= {{DATA_W{1'b0}}, mag(a)};
        mplier_q <= mag(b);
        acc_q    <= '0;
        cnt_q    <= '0;
        run_q    <= 1'b1;
        neg_q    <= a[DATA_W-1] ^ b[DATA_W-1];
      end else if (run_q) begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  // Sign applied at completion.
  always_comb begin
    product = neg_q ? $signed(-acc_q) : $signed(acc_q);
  end

  assign done = done_q;

endmodule

// File: rtl/horner_multiply_adder.sv
// One Horner step per start pulse: acc <= x*acc + a[sel] in signed Q(DATA_W-FRAC_W).FRAC_W.
// Optional macro HORNER_MAC_SATURATE_EN clamps the sum instead of wrapping it.
module horner_multiply_adder
  import horner_pkg::*;
#(
  parameter int unsigned                DATA_W   = DATA_W_DEFAULT,
  parameter int unsigned                FRAC_W   = FRAC_W_DEFAULT,
  parameter int unsigned                NUM_COEF = NUM_COEF_DEFAULT,
  parameter logic [NUM_COEF*DATA_W-1:0] COEFS    = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     adc_input_ready,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     multiplyadder_in_ready,
  input  logic [COEF_SEL_W-1:0]    coefficent_select,
  output logic                     multiplyadder_out_ready,
  output logic signed [DATA_W-1:0] multiplyadder_result,
  output logic                     busy,
  output logic                     overrun_err,
  output logic                     sel_err
);

  state_e                     state_q;
  logic signed [DATA_W-1:0]   x_q;
  logic signed [DATA_W-1:0]   acc_q;
  logic signed [DATA_W-1:0]   coef_q;
  logic                       out_ready_q;
  logic                       busy_q;
  logic                       overrun_q;
  logic                       sel_err_q;

  logic signed [DATA_W-1:0]   coef_mux;
  logic                       sel_bad;
  logic                       first_step;
  logic signed [DATA_W-1:0]   op_b;
  logic                       mult_start;
  logic                       mult_done;
  logic signed [2*DATA_W-1:0] mult_product;
  logic signed [2*DATA_W-1:0] prod_sh;
  logic signed [DATA_W+1:0]   sum;
  logic signed [DATA_W-1:0]   sum_red;
  logic                       unused_prod_bits;

  // Coefficient lookup; out-of-range selects contribute zero.
  always_comb begin
    coef_mux = '0;
    for (int k = 0; k < NUM_COEF; k++) begin
      if (coefficent_select == COEF_SEL_W'(k)) begin
        coef_mux = COEFS[k*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_bad    = coefficent_select > COEF_SEL_W'(NUM_COEF - 1);
  // The highest coefficient opens a new polynomial, so the old accumulator is discarded.
  assign first_step = coefficent_select == COEF_SEL_W'(NUM_COEF - 1);
  assign op_b       = first_step ? '0 : acc_q;
  assign mult_start = (state_q == StIdle) && multiplyadder_in_ready;

  horner_serial_mult #(
    .DATA_W (DATA_W)
  ) u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (mult_start),
    .a       (x_q),
    .b       (op_b),
    .done    (mult_done),
    .product (mult_product)
  );

  // Rescale the product back to FRAC_W fractional bits and add the coefficient.
  always_comb begin
    prod_sh = mult_product >>> FRAC_W;
    sum     = $signed(prod_sh[DATA_W+1:0]) + $signed({{2{coef_q[DATA_W-1]}}, coef_q});
  end

  assign unused_prod_bits = ^prod_sh[2*DATA_W-1:DATA_W+2];

`ifdef HORNER_MAC_SATURATE_EN
  localparam logic signed [DATA_W+1:0] SUM_MAX = (DATA_W + 2)'(sat_hi(DATA_W));
  localparam logic signed [DATA_W+1:0] SUM_MIN = (DATA_W + 2)'(sat_lo(DATA_W));

  // Clamp to the representable accumulator range.
  always_comb begin
    if (sum > SUM_MAX) begin
      sum_red = SUM_MAX[DATA_W-1:0];
    end else if (sum < SUM_MIN) begin
      sum_red = SUM_MIN[DATA_W-1:0];
    end else begin
      sum_red = sum[DATA_W-1:0];
    end
  end
`else
  // Two's-complement wrap to the accumulator width.
  always_comb begin
    sum_red = sum[DATA_W-1:0];
  end
`endif

  // Control FSM with registered handshake outputs, accumulator and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      x_q         <= '0;
      acc_q       <= '0;
      coef_q      <= '0;
      out_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      if (multiplyadder_in_ready && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          out_ready_q <= 1'b0;
          if (adc_input_ready) begin
            x_q <= x_in;
          end
          if (multiplyadder_in_ready) begin
            coef_q  <= coef_mux;
            busy_q  <= 1'b1;
            state_q <= StMul;
            if (sel_bad) begin
              sel_err_q <= 1'b1;
            end
          end
        end
        StMul: begin
          if (mult_done) begin
            acc_q       <= sum_red;
            out_ready_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          out_ready_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign multiplyadder_out_ready = out_ready_q;
  assign multiplyadder_result    = acc_q;
  assign busy                    = busy_q;
  assign overrun_err             = overrun_q;
  assign sel_err                 = sel_err_q;

endmodule

// File: tb/tb_horner_multiply_adder.sv
// Bench for horner_multiply_adder: four instances with different coefficient tables
// share one stimulus stream and are checked every cycle against an arithmetic model.
module tb_horner_multiply_adder;

  localparam int NI  = 4;
  localparam int LAT = 17;

  logic                clk;
  logic                reset;
  logic                adc_input_ready;
  logic signed [15:0]  x_in;
  logic                in_ready;
  logic [3:0]          sel;
  logic                out_rdy [NI];
  logic signed [15:0]  res     [NI];
  logic                busy    [NI];
  logic                ovr     [NI];
  logic                serr    [NI];

  int n_checks = 0;
  int n_pass   = 0;

  // Coefficient tables: set 0 single-step, 1 uniform 256, 2 overflow, 3 negative test.
  function automatic int coef_of(int s, int k);
    case (s)
      0:       return (k == 10) ? 4096 : (k == 9) ? 1024 : 0;
      1:       return 256;
      2:       return (k >= 9) ? 30000 : 0;
      default: return (k == 10) ? 4096 : 0;
    endcase
  endfunction

  function automatic logic [175:0] coef_set(int s);
    logic [175:0] v;
    v = '0;
    for (int k = 0; k < 11; k++) v[k*16 +: 16] = 16'(coef_of(s, k));
    return v;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    horner_multiply_adder #(
      .DATA_W   (16),
      .FRAC_W   (12),
      .NUM_COEF (11),
      .COEFS    (coef_set(g))
    ) u_dut (
      .clk                     (clk),
      .reset                   (reset),
      .adc_input_ready         (adc_input_ready),
      .x_in                    (x_in),
      .multiplyadder_in_ready  (in_ready),
      .coefficent_select       (sel),
      .multiplyadder_out_ready (out_rdy[g]),
      .multiplyadder_result    (res[g]),
      .busy                    (busy[g]),
      .overrun_err             (ovr[g]),
      .sel_err                 (serr[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One Horner step in plain integer arithmetic: floor((x*b)/4096) + coef, 18-bit sum.
  function automatic int horner(int x, int acc_in, int s, int set);
    longint p, q;
    int b, coef, r;
    b    = (s == 10) ? 0 : acc_in;
    coef = (s <= 10) ? coef_of(set, s) : 0;
    p    = longint'(x) * longint'(b);
    q    = p / 4096;
    if (p < 0 && (p % 4096) != 0) q = q - 1;
    r = int'(q) + coef;
    r = r & 32'h3FFFF;
    if (r >= 131072) r = r - 262144;
`ifdef HORNER_MAC_SATURATE_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`else
    r = r & 32'hFFFF;
    if (r >= 32768) r = r - 65536;
`endif
    return r;
  endfunction

  // Reference model: start accepted only when idle, result lands LAT edges later.
  int m_x;
  int m_acc  [NI];
  int m_pend [NI];
  int m_left;
  bit m_busy, m_rdy, m_ovr, m_serr;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_x <= 0; m_left <= 0;
      m_busy <= 0; m_rdy <= 0; m_ovr <= 0; m_serr <= 0;
      for (int i = 0; i < NI; i++) begin
        m_acc[i]  <= 0;
        m_pend[i] <= 0;
      end
    end else begin
      m_rdy <= 0;
      if (!m_busy) begin
        if (adc_input_ready) m_x <= int'(x_in);
        if (in_ready) begin
          m_busy <= 1;
          m_left <= LAT;
          if (int'(sel) > 10) m_serr <= 1;
          for (int i = 0; i < NI; i++) m_pend[i] <= horner(m_x, m_acc[i], int'(sel), i);
        end
      end else begin
        if (in_ready) m_ovr <= 1;
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_rdy <= 1;
          for (int i = 0; i < NI; i++) m_acc[i] <= m_pend[i];
        end
        if (m_left == 0) m_busy <= 0;
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d.out_ready", i), int'(out_rdy[i]), int'(m_rdy));
      chk($sformatf("u%0d.result", i), int'(res[i]), m_acc[i]);
      chk($sformatf("u%0d.busy", i), int'(busy[i]), int'(m_busy));
      chk($sformatf("u%0d.overrun_err", i), int'(ovr[i]), int'(m_ovr));
      chk($sformatf("u%0d.sel_err", i), int'(serr[i]), int'(m_serr));
    end
  end

  task automatic load_x(input int v);
    @(negedge clk);
    adc_input_ready = 1'b1;
    x_in = 16'(v);
    @(negedge clk);
    adc_input_ready = 1'b0;
  endtask

  // Issue one step, optionally pulse in_ready again extra_at cycles in, and wait for done.
  task automatic run_step(input int s, input int extra_at, output int lat);
    int cyc;
    @(negedge clk);
    sel = 4'(s);
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
    lat = -1;
    cyc = 0;
    while (lat < 0 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      in_ready = (cyc == extra_at);
      if (out_rdy[0]) lat = cyc;
    end
    in_ready = 1'b0;
    chk($sformatf("latency sel=%0d", s), lat, LAT);
    cyc = 0;
    while (busy[0] && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("busy drops after step", int'(busy[0]), 0);
  endtask

  initial begin
    int lat, pulses;
    reset = 1'b1;
    adc_input_ready = 1'b0;
    x_in = '0;
    in_ready = 1'b0;
    sel = '0;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("power-up result", int'(res[0]), 0);
    chk("power-up busy", int'(busy[0]), 0);

    // Populate state, set sel_err, then reset in the middle of a multiply.
    load_x(4096);
    run_step(10, 0, lat);
    chk("pre-reset step", int'(res[0]), 4096);
    run_step(12, 0, lat);
    chk("sel 12 sets sel_err", int'(serr[0]), 1);
    chk("sel 12 coef is zero", int'(res[0]), 4096);
    @(negedge clk);
    sel = 4'd10;
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset result", int'(res[0]), 0);
    chk("reset out_ready", int'(out_rdy[0]), 0);
    chk("reset busy", int'(busy[0]), 0);
    chk("reset sel_err", int'(serr[0]), 0);
    chk("reset overrun_err", int'(ovr[0]), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    load_x(4096);
    run_step(10, 0, lat);
    chk("after reset x=1 a10=1", int'(res[0]), 4096);

    // Single steps at x = 0.5.
    load_x(2048);
    run_step(10, 0, lat);
    chk("single sel10", int'(res[0]), 4096);
    run_step(9, 0, lat);
    chk("single sel9", int'(res[0]), 3072);

    // Full sequence at x = 1.0 with all coefficients 256.
    load_x(4096);
    pulses = 0;
    for (int s = 10; s >= 0; s--) begin
      run_step(s, 0, lat);
      if (lat > 0) pulses++;
    end
    chk("full sequence pulses", pulses, 11);
    chk("full sequence result", int'(res[1]), 2816);

    // Overflow of the sum.
    load_x(4096);
    run_step(10, 0, lat);
    run_step(9, 0, lat);
`ifdef HORNER_MAC_SATURATE_EN
    chk("overflow saturates", int'(res[2]), 32767);
`else
    chk("overflow wraps", int'(res[2]), -5536);
`endif

    // Start pulse during MUL is ignored and flagged.
    run_step(10, 5, lat);
    chk("overrun_err set", int'(ovr[0]), 1);
    pulses = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_rdy[0]) pulses++;
    end
    chk("no extra step from overrun", pulses, 0);

    // Negative operands.
    load_x(-2048);
    run_step(10, 0, lat);
    chk("negative sel10", int'(res[3]), 4096);
    run_step(9, 0, lat);
    chk("negative sel9", int'(res[3]), -2048);
    // -3 * 256 = -768, >>> 12 floors to -1.
    load_x(-3);
    run_step(10, 0, lat);
    run_step(9, 0, lat);
    chk("negative floor shift", int'(res[1]), 255);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
